// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared sizes, FSM state type and default access windows for mem_bus_arbiter
package mem_arb_pkg;

    localparam int AW   = 6;
    localparam int NREQ = 2;

    localparam int DEF_EN_LO = 12;
    localparam int DEF_EN_HI = 48;
    localparam int DEF_WR_LO = 12;
    localparam int DEF_WR_HI = 14;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    function automatic logic win_ok(
        input logic [AW-1:0] a,
        input logic          w,
        input int            en_lo,
        input int            en_hi,
        input int            wr_lo,
        input int            wr_hi
    );
        int ai;
        ai = int'(a);
        return (ai >= en_lo) && (ai <= en_hi) && (!w || ((ai >= wr_lo) && (ai <= wr_hi)));
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin pick with a pointer that favours the requester not granted last
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       pick
);

    logic ptr;

    assign pick = (&req) ? ptr : req[1];

    // pointer moves to the loser whenever a pick is consumed; reset favours requester 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (take)
            ptr <= ~pick;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester memory bus arbiter, IDLE/ACCESS/RESP per access; MEM_ARB_WIN_CHECK_EN enables address window checking
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DW    = 8,
    parameter int EN_LO = DEF_EN_LO,
    parameter int EN_HI = DEF_EN_HI,
    parameter int WR_LO = DEF_WR_LO,
    parameter int WR_HI = DEF_WR_HI
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic [DW-1:0]        rdata,
    output logic [AW-1:0]        addr,
    output logic                 wr,
    output logic                 en,
    output logic [DW-1:0]        wdata,
    input  logic [DW-1:0]        mem_rdata
);

`ifdef MEM_ARB_WIN_CHECK_EN
    localparam bit WIN_CHECK = 1'b1;
`else
    localparam bit WIN_CHECK = 1'b0;
`endif

    state_t          state;
    logic            pick;
    logic            sel_q;
    logic            rd_q;
    logic            bad_q;
    logic [AW-1:0]   p_addr;
    logic [DW-1:0]   p_wdata;
    logic            p_wr;
    logic            p_ok;
    logic [1:0]      p_hot;
    logic [1:0]      sel_hot;

    assign p_addr  = pick ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
    assign p_wdata = pick ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
    assign p_wr    = pick ? req_wr[1] : req_wr[0];
    assign p_ok    = WIN_CHECK ? win_ok(p_addr, p_wr, EN_LO, EN_HI, WR_LO, WR_HI) : 1'b1;
    assign p_hot   = pick ? 2'b10 : 2'b01;
    assign sel_hot = sel_q ? 2'b10 : 2'b01;
    assign rdata   = (state == RESP && rd_q) ? mem_rdata : '0;

    rr_arbiter_2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .take  (state == IDLE && |req),
        .pick  (pick)
    );

    // access sequencer: latch the pick in IDLE, drive memory in ACCESS, pulse completion in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel_q <= 1'b0;
            rd_q  <= 1'b0;
            bad_q <= 1'b0;
            gnt   <= '0;
            done  <= '0;
            err   <= '0;
            en    <= 1'b0;
            wr    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    state <= ACCESS;
                    sel_q <= pick;
                    rd_q  <= p_ok & ~p_wr;
                    bad_q <= ~p_ok;
                    gnt   <= p_hot;
                    addr  <= p_addr;
                    wdata <= p_wdata;
                    en    <= p_ok;
                    wr    <= p_ok & p_wr;
                end
                ACCESS: begin
                    state <= RESP;
                    gnt   <= '0;
                    en    <= 1'b0;
                    wr    <= 1'b0;
                    done  <= sel_hot;
                    err   <= bad_q ? sel_hot : 2'b00;
                end
                RESP: begin
                    state <= IDLE;
                    done  <= '0;
                    err   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
